// File: rtl/ifetch_queue_pkg.sv
// Shared fetch definitions: memory base, instruction size and the queue entry layout.
package fetch_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
  localparam logic [31:0] INSN_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(INSN_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: instruction memory port, redirect from execute, and decode handshake.
interface ifetch_queue_if;

  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        imem_read_write;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_insn;

  modport master (
    output imem_address, imem_read_write, out_valid, out_pc, out_insn,
    input  imem_data_in, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_address, imem_read_write, out_valid, out_pc, out_insn,
    output imem_data_in, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/ifetch_queue_fetch_queue.sv
// Circular in-order FIFO of fetch entries with flush; DEPTH must be a power of two >= 2.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every signal gets a default before the branches, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_pop)  head_d = head_q + AW'(1);
      if (do_push) tail_d = tail_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is reset on purpose so the head reads as zero after reset, not stale data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[tail_q] <= entry_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch initiator with prefetch queue and redirect flush.
// Define IFETCH_PERF_EN to add the perf_fetch_count / perf_redirect_count outputs.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = IMEM_BASE
) (
  input  logic              clock,
  input  logic              reset,
  ifetch_queue_if.master    bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_count,
  output logic [31:0]       perf_redirect_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          pop, enq;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  fetch_entry_t  q_head, q_wr;

  assign pop  = ~q_empty & bus.out_ready;
  // A full queue still accepts a fetch when the head leaves this cycle, so there is no bubble.
  assign enq  = ~bus.redirect_valid & ((q_count < DEPTH_C) | pop);
  assign q_wr = '{pc: fetch_pc_q, insn: bus.imem_data_in};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (enq),
    .entry_i (q_wr),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = word_align(bus.redirect_pc);
    else if (enq)           fetch_pc_d = fetch_pc_q + INSN_BYTES;
  end

  always_ff @(posedge clock) begin
    if (reset) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  assign bus.imem_address    = fetch_pc_q;
  assign bus.imem_read_write = 1'b0;
  assign bus.out_valid       = ~q_empty;
  assign bus.out_pc          = q_head.pc;
  assign bus.out_insn        = q_head.insn;

  no_overflow: assert property (@(posedge clock) disable iff (reset) enq |-> (!q_full || pop));

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (enq)                perf_fetch_q    <= perf_fetch_q + 32'd1;
      if (bus.redirect_valid) perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_fetch_count    = perf_fetch_q;
  assign perf_redirect_count = perf_redirect_q;
`endif

endmodule
